rs232_recv3: RTL and testbench

- Parametrised next-generation RS232 receiver: configurable data width, parity mode and stop-bit count.
- Adds start-bit validation, framing/parity error reporting, break-safe line recovery and a valid/ready output with CTS flow control.
- Sits between the board TXD pin and a byte FIFO or packet parser.
- Clock/baud ratio need not be an integer.

---
 rtl/rs232_recv3.sv | 177 +++++++++++++++++
 tb/tb_rs232_recv3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_recv3.sv
// rs232_recv3: parametrised RS232 receiver with start validation, parity/framing checks and break recovery.
// Latency: word presented one cycle after the last stop-bit decision (sync adds 2 cycles from the pin).
// Backpressure: valid/ready output; ctsn_pin mirrors ovalid; a frame completing against a held word is dropped and sets sticky overflow.
// Optional: RS232_MAJORITY_VOTE_EN enables 2-of-3 voting around each sample point (decisions one cycle later).
module rs232_recv3 #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 txd_pin,
    output logic                 ctsn_pin,
    output logic [DATA_BITS-1:0] odata,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 oferr,
    output logic                 operr,
    output logic                 overflow
);

    localparam real  UNIT      = CLOCK_FREQ / BAUD_RATE;
    localparam int   PAR_SLOTS = (PARITY != 0) ? 1 : 0;
    localparam int   NSLOTS    = 1 + DATA_BITS + PAR_SLOTS + STOP_BITS;
    localparam int   LAST_DATA = DATA_BITS;
    localparam int   LAST_SLOT = NSLOTS - 1;
    localparam int   MAX_CYC   = $rtoi(UNIT * (NSLOTS + 0.5)) + 4;
    localparam int   TW        = $clog2(MAX_CYC + 1);
    localparam int   SW        = $clog2(NSLOTS);
    localparam logic PAR_EXP   = (PARITY == 1);
`ifdef RS232_MAJORITY_VOTE_EN
    localparam int   VOTE_LAG  = 1;
`else
    localparam int   VOTE_LAG  = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state, state_nxt;
    logic                   sync_q1, txd_s;
    logic                   smp_bit;
    logic [TW-1:0]          timer;
    logic [SW-1:0]          slot;
    logic [DATA_BITS-1:0]   shreg;
    logic                   ferr_q, perr_q;
    logic                   busy, hit, frame_done, out_free;
    logic [TW-1:0]          sample_tab [NSLOTS];

    // Absolute decision cycle per slot, rounded once at elaboration so no error accumulates across the frame.
    for (genvar g = 0; g < NSLOTS; g++) begin : g_tab
        localparam int SC = $rtoi(UNIT * (g + 0.5) + 0.5) - 1 + VOTE_LAG;
        assign sample_tab[g] = TW'(SC);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            txd_s   <= 1'b1;
        end else begin
            sync_q1 <= txd_pin;
            txd_s   <= sync_q1;
        end
    end

`ifdef RS232_MAJORITY_VOTE_EN
    logic [1:0] hist;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], txd_s};
        end
    end

    // At decision cycle S+1: txd_s is S+1, hist[0] is S, hist[1] is S-1.
    assign smp_bit = (txd_s & hist[0]) | (txd_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign smp_bit = txd_s;
`endif

    assign busy       = (state == S_START) || (state == S_DATA) ||
                        (state == S_PARITY) || (state == S_STOP);
    assign hit        = busy && (timer == sample_tab[slot]);
    assign out_free   = !ovalid || oready;
    assign ctsn_pin   = ovalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!txd_s) state_nxt = S_START;
            end
            S_START: begin
                if (hit) state_nxt = smp_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (hit && (slot == SW'(LAST_DATA)))
                    state_nxt = (PAR_SLOTS != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (hit) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (hit && (slot == SW'(LAST_SLOT))) begin
                    frame_done = 1'b1;
                    // Leaving mid-bit lets the next start edge be caught even when the sender runs fast.
                    state_nxt  = smp_bit ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (txd_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            slot     <= '0;
            shreg    <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            odata    <= '0;
            ovalid   <= 1'b0;
            oferr    <= 1'b0;
            operr    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                // The cycle the low level is first seen is cycle 0, so the next one is cycle 1.
                timer  <= TW'(1);
                slot   <= '0;
                ferr_q <= 1'b0;
                perr_q <= 1'b0;
            end else if (busy) begin
                timer <= timer + 1'b1;
                if (hit && !frame_done) slot <= slot + 1'b1;
            end

            if (hit && (state == S_DATA)) shreg <= {smp_bit, shreg[DATA_BITS-1:1]};
            if (hit && (state == S_PARITY)) perr_q <= (^shreg) ^ smp_bit ^ PAR_EXP;
            if (hit && (state == S_STOP) && !smp_bit) ferr_q <= 1'b1;

            if (frame_done && out_free) begin
                odata  <= shreg;
                oferr  <= ferr_q | ~smp_bit;
                operr  <= perr_q;
                ovalid <= 1'b1;
            end else if (ovalid && oready) begin
                ovalid <= 1'b0;
            end

            if (frame_done && !out_free) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs232_recv3.sv
// Directed bench for rs232_recv3: 8N1 and 7E1 instances at UNIT=10 with hand-computed words, flags and timing.
`timescale 1ns/1ps
module tb_rs232_recv3;

`ifdef RS232_MAJORITY_VOTE_EN
    localparam int LAT = 98;
`else
    localparam int LAT = 97;
`endif

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       txd0    = 1'b1;
    logic       txd1    = 1'b1;
    logic       oready0 = 1'b1;
    logic       oready1 = 1'b1;
    logic       ctsn0, ovalid0, oferr0, operr0, overflow0;
    logic [7:0] odata0;
    logic       ctsn1, ovalid1, oferr1, operr1, overflow1;
    logic [6:0] odata1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [9:0] q0[$];
    logic [8:0] q1[$];
    int   vld_cyc0  = 0;
    int   rise_cyc0 = 0;
    logic ovalid0_d = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    rs232_recv3 #(
        .CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clock(clock), .reset(reset), .txd_pin(txd0), .ctsn_pin(ctsn0),
        .odata(odata0), .ovalid(ovalid0), .oready(oready0),
        .oferr(oferr0), .operr(operr0), .overflow(overflow0)
    );

    rs232_recv3 #(
        .CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clock(clock), .reset(reset), .txd_pin(txd1), .ctsn_pin(ctsn1),
        .odata(odata1), .ovalid(ovalid1), .oready(oready1),
        .oferr(oferr1), .operr(operr1), .overflow(overflow1)
    );

    always @(negedge clock) begin
        if (ovalid0 && oready0) q0.push_back({operr0, oferr0, odata0});
        if (ovalid1 && oready1) q1.push_back({operr1, oferr1, odata1});
        if (ovalid0) vld_cyc0++;
        if (ovalid0 && !ovalid0_d) rise_cyc0 = cyc;
        ovalid0_d = ovalid0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) txd0 = v;
        else           txd1 = v;
    endtask

    task automatic align();
        @(posedge clock);
        #2;
    endtask

    // par_mode: 0 none, 1 odd, 2 even; flip_par inverts the parity bit sent.
    task automatic send_frame(input int line, input logic [8:0] dat, input int nbits,
                              input int par_mode, input logic flip_par, input real bit_ns);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p ^= dat[i];
        if (par_mode == 1) p = ~p;
        p ^= flip_par;
        drive(line, 1'b0);
        #(bit_ns);
        for (int i = 0; i < nbits; i++) begin
            drive(line, dat[i]);
            #(bit_ns);
        end
        if (par_mode != 0) begin
            drive(line, p);
            #(bit_ns);
        end
        drive(line, 1'b1);
        #(bit_ns);
    endtask

    task automatic expect_word0(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        logic [9:0] w;
        check({tag, "_present"}, (q0.size() > 0), 1);
        if (q0.size() > 0) begin
            w = q0.pop_front();
            check({tag, "_odata"}, w[7:0], d);
            check({tag, "_oferr"}, w[8], fe);
            check({tag, "_operr"}, w[9], pe);
        end
    endtask

    task automatic expect_word1(input string tag, input logic [6:0] d, input logic fe, input logic pe);
        logic [8:0] w;
        check({tag, "_present"}, (q1.size() > 0), 1);
        if (q1.size() > 0) begin
            w = q1.pop_front();
            check({tag, "_odata"}, w[6:0], d);
            check({tag, "_oferr"}, w[7], fe);
            check({tag, "_operr"}, w[8], pe);
        end
    endtask

    initial begin
        int c0;
        int vbase;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ovalid", ovalid0, 0);
        check("rst_odata", odata0, 0);
        check("rst_oferr", oferr0, 0);
        check("rst_operr", operr0, 0);
        check("rst_overflow", overflow0, 0);
        check("rst_ctsn", ctsn0, 0);
        check("rst_ovalid_p", ovalid1, 0);
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // Single 8N1 frame: exact decision timing and one-cycle valid pulse.
        align();
        c0    = cyc;
        vbase = vld_cyc0;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 100.0);
        #200;
        check("a5_latency", rise_cyc0 - c0, LAT);
        check("a5_vld_cycles", vld_cyc0 - vbase, 1);
        expect_word0("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_qempty", q0.size(), 0);

        // Back-to-back frames from a 2% fast sender.
        align();
        send_frame(0, 9'h03C, 8, 0, 1'b0, 98.0);
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 98.0);
        send_frame(0, 9'h0FF, 8, 0, 1'b0, 98.0);
        #200;
        expect_word0("b2b0", 8'h3C, 1'b0, 1'b0);
        expect_word0("b2b1", 8'hC3, 1'b0, 1'b0);
        expect_word0("b2b2", 8'hFF, 1'b0, 1'b0);
        check("b2b_overflow", overflow0, 0);

        // 7E1: 0x41 has even parity bit 0; first sent flipped.
        align();
        send_frame(1, 9'h041, 7, 2, 1'b1, 100.0);
        #200;
        expect_word1("par_bad", 7'h41, 1'b0, 1'b1);
        align();
        send_frame(1, 9'h041, 7, 2, 1'b0, 100.0);
        #200;
        expect_word1("par_ok", 7'h41, 1'b0, 1'b0);

        // Three-cycle low glitch on an idle line.
        vbase = vld_cyc0;
        align();
        txd0 = 1'b0;
        #30;
        txd0 = 1'b1;
        #400;
        check("glitch_no_vld", vld_cyc0 - vbase, 0);
        check("glitch_qempty", q0.size(), 0);

        // Reset asserted during data bit 4, held until the sender finishes.
        vbase = vld_cyc0;
        align();
        fork
            send_frame(0, 9'h0F0, 8, 0, 1'b0, 100.0);
            begin
                #450;
                reset = 1'b1;
            end
        join
        #100;
        reset = 1'b0;
        #200;
        check("rstmid_no_vld", vld_cyc0 - vbase, 0);
        check("rstmid_qempty", q0.size(), 0);
        align();
        send_frame(0, 9'h096, 8, 0, 1'b0, 100.0);
        #200;
        expect_word0("rstmid_next", 8'h96, 1'b0, 1'b0);

        // Break: 30 bit times low yields one framing-error word, then waits for the line to rise.
        vbase = vld_cyc0;
        align();
        txd0 = 1'b0;
        #3000;
        check("brk_words", q0.size(), 1);
        check("brk_vld_cycles", vld_cyc0 - vbase, 1);
        txd0 = 1'b1;
        expect_word0("brk", 8'h00, 1'b1, 1'b0);
        #300;
        align();
        send_frame(0, 9'h055, 8, 0, 1'b0, 100.0);
        #200;
        expect_word0("brk_next", 8'h55, 1'b0, 1'b0);

        // Consumer stalled: second frame dropped, first held.
        @(posedge clock);
        #1;
        oready0 = 1'b0;
        align();
        send_frame(0, 9'h011, 8, 0, 1'b0, 100.0);
        send_frame(0, 9'h022, 8, 0, 1'b0, 100.0);
        #200;
        check("ovf_ovalid", ovalid0, 1);
        check("ovf_odata", odata0, 8'h11);
        check("ovf_ctsn", ctsn0, 1);
        check("ovf_overflow", overflow0, 1);
        check("ovf_qempty", q0.size(), 0);
        @(posedge clock);
        #1;
        oready0 = 1'b1;
        @(posedge clock);
        #1;
        check("ovf_ovalid_drop", ovalid0, 0);
        check("ovf_ctsn_drop", ctsn0, 0);
        check("ovf_sticky", overflow0, 1);
        expect_word0("ovf_acc", 8'h11, 1'b0, 1'b0);
        check("ovf_qempty_end", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
